// File: rtl/ps_reg_slice.sv
// Two-entry register slice (main + skid) for a valid/ready stream.
// Full throughput; s_rdy is registered so no combinational path from m_rdy back to s_rdy.
module ps_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_dat,
  input  logic             s_val,
  output logic             s_rdy,
  output logic [WIDTH-1:0] m_dat,
  output logic             m_val,
  input  logic             m_rdy
);

  logic             main_full;
  logic             skid_full;
  logic [WIDTH-1:0] main_dat;
  logic [WIDTH-1:0] skid_dat;
  logic             push;
  logic             load_main;

  assign s_rdy     = !skid_full;
  assign push      = s_val & s_rdy;
  assign load_main = !main_full | m_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_full <= 1'b0;
      skid_full <= 1'b0;
      main_dat  <= '0;
      skid_dat  <= '0;
    end else if (load_main) begin
      // skid is only ever full while main is full, so it always drains first
      if (skid_full) begin
        main_dat  <= skid_dat;
        main_full <= 1'b1;
        skid_full <= 1'b0;
      end else begin
        main_full <= push;
        if (push) main_dat <= s_dat;
      end
    end else if (push) begin
      skid_dat  <= s_dat;
      skid_full <= 1'b1;
    end
  end

  assign m_dat = main_dat;
  assign m_val = main_full;

endmodule

// File: rtl/ps_wrr_arbitrator.sv
// Weighted round-robin packet arbiter: grant held per packet, up to weight packets per turn,
// output registered through ps_reg_slice and tagged with the source channel number.
module ps_wrr_arbitrator #(
  parameter int WIDTH   = 8,
  parameter int SINKS   = 4,
  parameter int WEIGHTW = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SINKS-1:0][WIDTH-1:0]     i_dat,
  input  logic [SINKS-1:0]                i_val,
  input  logic [SINKS-1:0]                i_eop,
  output logic [SINKS-1:0]                i_rdy,
  input  logic [SINKS-1:0][WEIGHTW-1:0]   i_weight,
  output logic [WIDTH-1:0]                o_dat,
  output logic                            o_val,
  output logic                            o_eop,
  output logic [$clog2(SINKS)-1:0]        o_num,
  input  logic                            o_rdy
);

  localparam int NUMW = $clog2(SINKS);
  localparam int SW   = NUMW + 1 + WIDTH;

  logic               lock;
  logic [NUMW-1:0]    sel_q;
  logic [NUMW-1:0]    ptr;
  logic [NUMW-1:0]    owner;
  logic [WEIGHTW-1:0] cnt;

  logic               s_rdy;
  logic [NUMW-1:0]    srch;
  logic               found;
  logic [NUMW-1:0]    winner;
  logic               accept;
  logic [WEIGHTW-1:0] wt;
  logic [WEIGHTW-1:0] reload;
  logic [WEIGHTW-1:0] credit;
  logic [WEIGHTW-1:0] cnt_nxt;
  logic [NUMW-1:0]    ptr_next_src;
  logic [SW-1:0]      slice_in;
  logic [SW-1:0]      slice_out;

  // rotating search: first requesting source at or above ptr, wrapping
  always_comb begin
    srch  = '0;
    found = 1'b0;
    for (int k = 0; k < SINKS; k++) begin
      if (!found && i_val[(int'(ptr) + k) % SINKS]) begin
        found = 1'b1;
        srch  = NUMW'((int'(ptr) + k) % SINKS);
      end
    end
  end

  assign winner = lock ? sel_q : srch;

  always_comb begin
    i_rdy = '0;
    if (!reset && (lock || found) && s_rdy) i_rdy[winner] = 1'b1;
  end

  assign accept = i_val[winner] & i_rdy[winner];

  // leftover credit counts only if the same source wins again back-to-back
  assign wt           = i_weight[winner];
  assign reload       = (wt == '0) ? WEIGHTW'(1) : wt;
  assign credit       = (winner == owner && cnt != '0) ? cnt : reload;
  assign cnt_nxt      = credit - 1'b1;
  assign ptr_next_src = (winner == NUMW'(SINKS - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock  <= 1'b0;
      sel_q <= '0;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (i_eop[winner]) begin
        lock  <= 1'b0;
        cnt   <= cnt_nxt;
        owner <= winner;
        ptr   <= (cnt_nxt == '0) ? ptr_next_src : winner;
      end else if (!lock) begin
        lock  <= 1'b1;
        sel_q <= winner;
      end
    end
  end

  assign slice_in = {winner, i_eop[winner], i_dat[winner]};

  ps_reg_slice #(.WIDTH(SW)) u_slice (
    .clk   (clk),
    .reset (reset),
    .s_dat (slice_in),
    .s_val (accept),
    .s_rdy (s_rdy),
    .m_dat (slice_out),
    .m_val (o_val),
    .m_rdy (o_rdy)
  );

  assign o_num = slice_out[SW-1 -: NUMW];
  assign o_eop = slice_out[WIDTH];
  assign o_dat = slice_out[WIDTH-1:0];

endmodule

// File: doc/ps_wrr_arbitrator.md
# ps_wrr_arbitrator

Weighted round-robin arbiter for PacketStream with registered output. It merges SINKS input streams into one output and holds the grant for a whole packet (val/eop framing). Each source may send up to its programmed weight of packets per turn before priority rotates. The output carries the source channel number and passes through a full-throughput two-entry register slice, so the block can sit between packet sources and a shared link without combinational paths from o_rdy to i_rdy.

## Interface
- WIDTH, 8, data width
- SINKS, 4, number of input streams (≥ 2)
- WEIGHTW, 4, width of each per-source weight
- NUMW, $clog2(SINKS) (localparam), width of channel number
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_dat  in  [SINKS-1:0][WIDTH-1:0]  input data
- i_val  in  [SINKS-1:0]  input valid
- i_eop  in  [SINKS-1:0]  input end of packet
- i_rdy  out  [SINKS-1:0]  input ready, at most one bit set
- i_weight  in  [SINKS-1:0][WEIGHTW-1:0]  packets per turn; quasi-static; 0 treated as 1
- o_dat  out  WIDTH  output data
- o_val  out  1  output valid
- o_eop  out  1  output end of packet
- o_num  out  NUMW  source channel of current beat
- o_rdy  in  1  output ready

## Operation
- Internal state: lock flag, sel_q (NUMW), ptr (NUMW, rotating priority start), owner (NUMW), cnt (WEIGHTW, remaining credit).
- Internal ready s_rdy means the slice can accept a beat (see Timing).
- Unlocked: winner = first i_val bit at or above ptr, wrapping modulo SINKS. i_rdy = onehot(winner) & s_rdy. If no i_val bit is set, i_rdy = 0.
- Locked: winner = sel_q. i_rdy = onehot(sel_q) & s_rdy. Other inputs are ignored, whatever their i_val.
- A beat is accepted when i_val[winner] & i_rdy[winner].
- Accepted beat with eop=0 while unlocked: lock=1, sel_q=winner.
- Accepted beat with eop=1: lock=0. A single-beat packet never locks.
- Credit update on every accepted eop beat from source w:
  - Effective credit c = cnt if (w==owner && cnt≠0), else max(i_weight[w],1).
  - New cnt = c−1; owner = w.
  - ptr = (c−1==0) ? (w+1 mod SINKS) : w.
- A source keeps priority only while it still has credit. If it drops i_val, the winner search passes it and its leftover credit is discarded, because owner changes.
- i_weight is sampled only at credit reload. Changes mid-turn take effect at the next reload.
- Beats are forwarded unmodified: {dat, eop, num=winner} go into the slice.

## Timing
- Latency is 1 cycle from input acceptance to o_val.
- Throughput is 1 beat/cycle, including across packet boundaries and grant switches (no bubble).
- Register slice: main register plus skid register.
  - s_rdy = !skid_full (a registered signal).
  - If o_rdy is low while the main register is full, the incoming beat goes to skid.
  - Skid drains into main when o_rdy returns.
- Output holds o_dat/o_eop/o_num stable while o_val & !o_rdy.
- Reset (asynchronous): o_val=0, o_eop=0, o_dat=0, o_num=0, both slice entries empty, lock=0, ptr=0, owner=0, cnt=0.
- i_rdy is forced to 0 while reset is asserted.
- Reset in the middle of a packet drops the partial packet and buffered beats. After release, arbitration restarts from source 0.
- Simultaneous eop acceptance and new requests: the next cycle arbitrates with the updated ptr and cnt.
- The winner search does not consider weights. Weights affect only ptr advance.

## Structure
- No shared package required. NUMW and the onehot/rotating-search helpers are local to the module.
- One sub-module: ps_reg_slice (two-entry skid register, parameter WIDTH, carrying {num, eop, dat}). It is reusable elsewhere in the stream library.
- Arbitration logic (search, lock, credit, ptr) stays in the top module.

## Test plan
- Reset mid-packet: assert reset during beat 2 of a 4-beat packet from source 1 -> o_val=0 immediately; i_rdy=0 during reset; after release, the next grant goes to the lowest valid source ≥ 0.
- Weights {1,1,1,1}, all sources send continuous single-beat packets, o_rdy=1 -> o_num sequence 0,1,2,3,0,… with no idle cycles.
- Weights {3,1,0,2}, all sources continuously valid, single-beat packets -> o_num sequence 0,0,0,1,2,3,3,0,0,0,…; weight 0 behaves as 1.
- Packet integrity: source 0 sends a 5-beat packet while source 1 is valid from cycle 1 -> all 5 beats of source 0 are output contiguously with o_num=0, then source 1 starts the following cycle.
- Backpressure: random o_rdy at 50% with 3 sources of random-length packets -> no beat lost or duplicated; output stable while stalled; per-source order is preserved; packets are never interleaved.
- Credit discard: weight[2]=4, source 2 sends 1 packet then drops i_val while source 3 is valid -> source 3 is granted next; when source 2 is valid again, it reloads 4 credits.
